pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID register. Owns the PC and issues
//  requests to instruction memory with a req/ack handshake. Buffers returned words in a
//  2-entry output queue (head + skid) and presents them as if_pc/if_inst/if_valid to IF/ID.
//  Honours downstream stall, delayed-branch redirect (one delay slot) and exception flush.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  PC of the first fetch after reset
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   reset, synchronous, active-high
//  stall          in   1   1 = IF/ID not accepting; head entry must be held
//  flush          in   1   exception/eret redirect, discards everything in flight
//  flush_pc       in   32  new PC when flush=1
//  branch_flag    in   1   taken branch/jump currently in ID (valid only when stall=0)
//  branch_target  in   32  target of that branch
//  inst_req       out  1   memory request
//  inst_addr      out  32  request address, stable while inst_req=1 and inst_ack=0
//  inst_ack       in   1   memory accepts and returns data this cycle
//  inst_rdata     in   32  instruction word, valid when inst_ack=1
//  if_pc          out  32  PC of head entry
//  if_inst        out  32  instruction of head entry
//  if_valid       out  1   head entry valid
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, inst_req=0, inst_addr=RESET_PC,
//    if_valid=0, if_pc=RESET_PC, if_inst=0, skid empty, drop=0, redirect_pend=0.
//    rst dominates flush and branch_flag; reset mid-request abandons it (ack ignored).
//  - States: IDLE (no request), REQ (request outstanding). At most one outstanding request.
//  - IDLE->REQ when queue occupancy after this cycle's consume is <=1; inst_req registered,
//    so the first request appears the cycle after reset deasserts, inst_addr=pc.
//  - REQ: hold inst_req=1, inst_addr constant until inst_ack. On ack: pc<=pc+4 (or target,
//    see branch), data enqueued unless drop=1; then REQ again if room, else IDLE.
//  - Enqueue: into head if head empty or consumed this cycle (if_valid & ~stall), else skid.
//    Consume: if_valid & ~stall pops head; skid moves to head in the same cycle.
//    Queue never overflows: no request is issued while both entries are full.
//  - Minimum latency: ack in cycle N -> if_valid=1 with that word in cycle N+1.
//  - stall=1: if_pc/if_inst/if_valid frozen; an outstanding request still completes into skid.
//  - flush=1 (priority over branch): head and skid cleared (if_valid=0 next cycle);
//    outstanding request marked drop=1 (its ack discarded, returns to IDLE/REQ normally);
//    pc<=flush_pc; redirect_pend cleared. Next issued address = flush_pc.
//  - branch_flag=1 & stall=0: the delay slot is the oldest of {head not consumed this
//    cycle, skid, in-flight, next-to-issue at pc}. Keep it; discard all younger
//    (skid cleared / in-flight drop=1 as applicable). Fetch after the delay slot starts at
//    branch_target: if the delay slot is not yet issued, set redirect_pend and pc<=target
//    on its ack; otherwise pc<=branch_target immediately.
//  - Simultaneous flush and ack: ack data discarded, pc=flush_pc.
//  - PC arithmetic 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. Targets used unaligned as given.
// TESTING
//  1. Reset then inst_ack=1 every req cycle -> inst_addr BFC00000,04,08..; if_pc follows
//     one cycle later, one instruction per cycle, if_valid stays 1.
//  2. stall=1 for 3 cycles with ack always 1 -> head held, skid fills, inst_req drops;
//     after stall=0 next two if_pc are the held and skid words, no loss or duplication.
//  3. ack delayed 4 cycles -> inst_addr/inst_req constant throughout, if_valid=0 until ack+1.
//  4. branch_flag with target 0x80000100 while PC=0x..10 in head -> 0x..10 delivered
//     (delay slot), next if_pc=0x80000100, younger words never appear.
//  5. flush with flush_pc=0xBFC00380 while request outstanding and skid full -> if_valid=0
//     next cycle, late ack word dropped, next if_pc=0xBFC00380.
//  6. rst asserted mid-request, ack arrives same cycle -> all outputs at reset values, ack ignored.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
//   inst_req   : fetch -> memory, request valid
//   inst_addr  : fetch -> memory, request address, held until acknowledged
//   inst_ack   : memory -> fetch, request accepted and data returned this cycle
//   inst_rdata : memory -> fetch, instruction word, valid with inst_ack
interface pc_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues one request at a time on imem, buffers returned words in a
// two-entry queue (head + skid) and presents the head as if_pc/if_inst/if_valid.
// Handles downstream stall, delayed branches (one delay slot) and exception flush.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   stall                  IF/ID not accepting; head is held
//   flush, flush_pc        discard everything in flight, restart at flush_pc
//   branch_flag/target     taken branch in ID (qualified by stall=0)
//   imem                   instruction-memory request bus (master side)
//   if_pc/if_inst/if_valid head entry presented to IF/ID
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    pc_fetch_if.master  imem,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    // Registered state
    state_t          state;
    logic [XLEN-1:0] pc;            // next address to issue
    logic            req_q;
    logic [XLEN-1:0] addr_q;        // address of the outstanding request
    logic            head_v;
    entry_t          head;
    logic            skid_v;
    entry_t          skid;
    logic            drop;          // outstanding request's data is to be discarded
    logic            redirect_pend; // delay slot not yet issued; fetch after it goes to target
    logic [XLEN-1:0] redirect_target;

    // Per-cycle decode
    logic            ack;
    logic            consume;
    logic            in_flight_live;
    logic            br;
    logic            br_head;
    logic            br_flight;
    logic            br_next;
    logic            enq;
    logic            issue;
    logic [XLEN-1:0] eff_pc;
    logic            pend_n;
    logic [XLEN-1:0] tgt_n;
    logic            head_v_n;
    entry_t          head_n;
    logic            skid_v_n;
    entry_t          skid_n;

    // Handshake, redirect and queue next-state decode.
    always_comb begin
        ack            = (state == REQ) && imem.inst_ack;
        consume        = head_v && !stall;
        in_flight_live = (state == REQ) && !drop;

        // Delay slot selection: head (delivered this cycle), else the live in-flight
        // request, else the next address still to be issued.
        br        = branch_flag && !stall && !flush;
        br_head   = br && head_v;
        br_flight = br && !head_v && in_flight_live;
        br_next   = br && !head_v && !in_flight_live;

        // A branch with the delay slot in head makes any in-flight return younger.
        enq = ack && !drop && !flush && !br_head;

        eff_pc = pc;
        pend_n = redirect_pend;
        tgt_n  = redirect_target;
        if (flush) begin
            eff_pc = flush_pc;
            pend_n = 1'b0;
        end else if (br_head || br_flight) begin
            eff_pc = branch_target;
            pend_n = 1'b0;
        end else if (br_next) begin
            pend_n = 1'b1;
            tgt_n  = branch_target;
        end

        head_v_n = head_v;
        head_n   = head;
        skid_v_n = skid_v;
        skid_n   = skid;
        if (flush) begin
            head_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else begin
            if (br_head) begin
                skid_v_n = 1'b0;
            end
            if (consume) begin
                head_v_n = skid_v_n;
                head_n   = skid_n;
                skid_v_n = 1'b0;
            end
            if (enq) begin
                if (!head_v_n) begin
                    head_v_n = 1'b1;
                    head_n   = entry_t'{pc: addr_q, inst: imem.inst_rdata};
                end else begin
                    skid_v_n = 1'b1;
                    skid_n   = entry_t'{pc: addr_q, inst: imem.inst_rdata};
                end
            end
        end

        // A new request only goes out if its return is guaranteed a free slot.
        issue = ((state == IDLE) || ack) && !(head_v_n && skid_v_n);
    end

    // Fetch FSM, PC and queue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            req_q           <= 1'b0;
            addr_q          <= RESET_PC;
            head_v          <= 1'b0;
            head            <= entry_t'{pc: RESET_PC, inst: '0};
            skid_v          <= 1'b0;
            skid            <= '0;
            drop            <= 1'b0;
            redirect_pend   <= 1'b0;
            redirect_target <= '0;
        end else begin
            head_v <= head_v_n;
            head   <= head_n;
            skid_v <= skid_v_n;
            skid   <= skid_n;
            if (issue) begin
                state         <= REQ;
                req_q         <= 1'b1;
                addr_q        <= eff_pc;
                pc            <= pend_n ? tgt_n : eff_pc + XLEN'(4);
                drop          <= 1'b0;
                redirect_pend <= 1'b0;
            end else begin
                pc              <= eff_pc;
                redirect_pend   <= pend_n;
                redirect_target <= tgt_n;
                if ((state == REQ) && !ack) begin
                    drop <= drop || flush || br_head;
                end else begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    drop  <= 1'b0;
                end
            end
        end
    end

    assign imem.inst_req  = req_q;
    assign imem.inst_addr = addr_q;
    assign if_valid       = head_v;
    assign if_pc          = head.pc;
    assign if_inst        = head.inst;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch. Memory returns inst_addr ^ KEY as the word.
module tb_pc_fetch;

    localparam logic [31:0] RPC = 32'hBFC0_0000;
    localparam logic [31:0] KEY = 32'h1234_5678;
    localparam logic [31:0] FPC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .imem          (bus.master),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    assign bus.inst_rdata = bus.inst_addr ^ KEY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        flush_pc      = '0;
        branch_flag   = 1'b0;
        branch_target = '0;
        bus.inst_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", bus.inst_req);
        end
        n_checks++;
        if (bus.inst_addr !== RPC) begin
            n_fail++; $display("FAIL reset_addr: got %h want %h", bus.inst_addr, RPC);
        end
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid);
        end
        n_checks++;
        if (if_pc !== RPC) begin
            n_fail++; $display("FAIL reset_pc: got %h want %h", if_pc, RPC);
        end
        n_checks++;
        if (if_inst !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst: got %h want 0", if_inst);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        n_checks++;
        if ({bus.inst_req, bus.inst_addr, if_valid} !== {1'b1, RPC, 1'b0}) begin
            n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                               bus.inst_req, bus.inst_addr, if_valid, RPC);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            e = RPC + 32'(4 * k);
            n_checks++;
            if ({if_valid, if_pc, if_inst} !== {1'b1, e, e ^ KEY}) begin
                n_fail++; $display("FAIL stream_head%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                   k, if_valid, if_pc, if_inst, e, e ^ KEY);
            end
            n_checks++;
            if ({bus.inst_req, bus.inst_addr} !== {1'b1, e + 32'd4}) begin
                n_fail++; $display("FAIL stream_addr%0d: got req=%b addr=%h want req=1 addr=%h",
                                   k, bus.inst_req, bus.inst_addr, e + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if_valid, if_pc, bus.inst_req} !== {1'b1, RPC, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h req=%b want v=1 pc=%h req=0",
                                   i, if_valid, if_pc, bus.inst_req, RPC);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, RPC + 32'd4, (RPC + 32'd4) ^ KEY}) begin
            n_fail++; $display("FAIL stall_skid_word: got v=%b pc=%h inst=%h want pc=%h",
                               if_valid, if_pc, if_inst, RPC + 32'd4);
        end
        n_checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, RPC + 32'd8}) begin
            n_fail++; $display("FAIL stall_resume_req: got req=%b addr=%h want req=1 addr=%h",
                               bus.inst_req, bus.inst_addr, RPC + 32'd8);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, RPC + 32'd8}) begin
            n_fail++; $display("FAIL stall_next_word: got v=%b pc=%h want pc=%h",
                               if_valid, if_pc, RPC + 32'd8);
        end
    endtask

    task automatic test_slow_ack();
        do_reset();
        bus.inst_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.inst_req, bus.inst_addr, if_valid} !== {1'b1, RPC, 1'b0}) begin
                n_fail++; $display("FAIL slow_wait%0d: got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                                   i, bus.inst_req, bus.inst_addr, if_valid, RPC);
            end
        end
        bus.inst_ack = 1'b1;
        tick();
        bus.inst_ack = 1'b0;
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, RPC, RPC ^ KEY}) begin
            n_fail++; $display("FAIL slow_data: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                               if_valid, if_pc, if_inst, RPC, RPC ^ KEY);
        end
        n_checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, RPC + 32'd4}) begin
            n_fail++; $display("FAIL slow_next_req: got req=%b addr=%h want addr=%h",
                               bus.inst_req, bus.inst_addr, RPC + 32'd4);
        end
        tick();
        n_checks++;
        if ({if_valid, bus.inst_req, bus.inst_addr} !== {1'b0, 1'b1, RPC + 32'd4}) begin
            n_fail++; $display("FAIL slow_drain: got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                               if_valid, bus.inst_req, bus.inst_addr, RPC + 32'd4);
        end
    endtask

    task automatic test_branch();
        do_reset();
        bus.inst_ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, RPC + 32'h10}) begin
            n_fail++; $display("FAIL branch_slot: got v=%b pc=%h want pc=%h", if_valid, if_pc, RPC + 32'h10);
        end
        branch_flag   = 1'b1;
        branch_target = 32'h8000_0100;
        tick();
        branch_flag = 1'b0;
        n_checks++;
        if ({if_valid, bus.inst_req, bus.inst_addr} !== {1'b0, 1'b1, 32'h8000_0100}) begin
            n_fail++; $display("FAIL branch_redirect: got v=%b req=%b addr=%h want v=0 req=1 addr=80000100",
                               if_valid, bus.inst_req, bus.inst_addr);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h8000_0100, 32'h8000_0100 ^ KEY}) begin
            n_fail++; $display("FAIL branch_target_word: got v=%b pc=%h inst=%h want pc=80000100",
                               if_valid, if_pc, if_inst);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h8000_0104}) begin
            n_fail++; $display("FAIL branch_seq: got v=%b pc=%h want pc=80000104", if_valid, if_pc);
        end
    endtask

    task automatic test_branch_inflight();
        do_reset();
        bus.inst_ack = 1'b0;
        tick();
        branch_flag   = 1'b1;
        branch_target = 32'h8000_0200;
        tick();
        branch_flag = 1'b0;
        n_checks++;
        if ({bus.inst_req, bus.inst_addr, if_valid} !== {1'b1, RPC, 1'b0}) begin
            n_fail++; $display("FAIL brf_hold: got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                               bus.inst_req, bus.inst_addr, if_valid, RPC);
        end
        bus.inst_ack = 1'b1;
        tick();
        n_checks++;
        if ({if_valid, if_pc, bus.inst_addr} !== {1'b1, RPC, 32'h8000_0200}) begin
            n_fail++; $display("FAIL brf_slot: got v=%b pc=%h addr=%h want pc=%h addr=80000200",
                               if_valid, if_pc, bus.inst_addr, RPC);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h8000_0200}) begin
            n_fail++; $display("FAIL brf_target: got v=%b pc=%h want pc=80000200", if_valid, if_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        tick();
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        tick();
        branch_flag = 1'b0;
        n_checks++;
        if ({if_valid, bus.inst_addr} !== {1'b0, 32'hFFFF_FFF8}) begin
            n_fail++; $display("FAIL wrap_redirect: got v=%b addr=%h want v=0 addr=fffffff8",
                               if_valid, bus.inst_addr);
        end
        tick();
        tick();
        n_checks++;
        if ({if_pc, bus.inst_addr} !== {32'hFFFF_FFFC, 32'h0}) begin
            n_fail++; $display("FAIL wrap_addr: got pc=%h addr=%h want pc=fffffffc addr=0",
                               if_pc, bus.inst_addr);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, KEY}) begin
            n_fail++; $display("FAIL wrap_zero: got v=%b pc=%h inst=%h want pc=0 inst=%h",
                               if_valid, if_pc, if_inst, KEY);
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        tick();
        bus.inst_ack = 1'b0;
        stall        = 1'b1;
        tick();
        flush    = 1'b1;
        flush_pc = FPC;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({if_valid, bus.inst_req, bus.inst_addr} !== {1'b0, 1'b1, RPC + 32'd4}) begin
            n_fail++; $display("FAIL flush_clear: got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                               if_valid, bus.inst_req, bus.inst_addr, RPC + 32'd4);
        end
        stall        = 1'b0;
        bus.inst_ack = 1'b1;
        tick();
        n_checks++;
        if ({if_valid, bus.inst_addr} !== {1'b0, FPC}) begin
            n_fail++; $display("FAIL flush_late_drop: got v=%b addr=%h want v=0 addr=%h",
                               if_valid, bus.inst_addr, FPC);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, FPC, FPC ^ KEY}) begin
            n_fail++; $display("FAIL flush_new_word: got v=%b pc=%h inst=%h want pc=%h",
                               if_valid, if_pc, if_inst, FPC);
        end
    endtask

    task automatic test_flush_skid();
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        tick();
        n_checks++;
        if (bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL fskid_full: got req=%b want 0", bus.inst_req);
        end
        flush    = 1'b1;
        flush_pc = FPC;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        n_checks++;
        if ({if_valid, bus.inst_req, bus.inst_addr} !== {1'b0, 1'b1, FPC}) begin
            n_fail++; $display("FAIL fskid_clear: got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                               if_valid, bus.inst_req, bus.inst_addr, FPC);
        end
        tick();
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, FPC + 32'd4}) begin
            n_fail++; $display("FAIL fskid_seq: got v=%b pc=%h want pc=%h", if_valid, if_pc, FPC + 32'd4);
        end
    endtask

    task automatic test_flush_ack();
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        tick();
        flush    = 1'b1;
        flush_pc = FPC;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({if_valid, bus.inst_addr} !== {1'b0, FPC}) begin
            n_fail++; $display("FAIL fack_drop: got v=%b addr=%h want v=0 addr=%h", if_valid, bus.inst_addr, FPC);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, FPC}) begin
            n_fail++; $display("FAIL fack_word: got v=%b pc=%h want pc=%h", if_valid, if_pc, FPC);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.inst_ack = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus.inst_req, bus.inst_addr, if_valid, if_pc, if_inst} !== {1'b0, RPC, 1'b0, RPC, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_state: got req=%b addr=%h v=%b pc=%h inst=%h want req=0 addr=%h v=0 pc=%h inst=0",
                               bus.inst_req, bus.inst_addr, if_valid, if_pc, if_inst, RPC, RPC);
        end
        tick();
        n_checks++;
        if ({bus.inst_req, bus.inst_addr, if_valid} !== {1'b1, RPC, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_restart: got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                               bus.inst_req, bus.inst_addr, if_valid, RPC);
        end
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, RPC}) begin
            n_fail++; $display("FAIL rstmid_first: got v=%b pc=%h want pc=%h", if_valid, if_pc, RPC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_slow_ack();
        test_branch();
        test_branch_inflight();
        test_wrap();
        test_flush_inflight();
        test_flush_skid();
        test_flush_ack();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
